// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the CPU, FDC and SDRAM-port signals around sdram_port_arbiter.
// slave = arbiter view (serves requesters, drives the sdram toggle port).
// master = environment view (requesters plus sdram controller).
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [7:0]        cpu_d;
  logic [7:0]        cpu_q;
  logic              cpu_ack;

  logic              fdc_req;
  logic              fdc_we;
  logic [ADDR_W-1:0] fdc_a;
  logic [7:0]        fdc_d;
  logic [7:0]        fdc_q;
  logic              fdc_ack;

  logic              sd_req;
  logic              sd_ack;
  logic [ADDR_W-2:0] sd_a;
  logic [1:0]        sd_ds;
  logic              sd_we;
  logic [15:0]       sd_d;
  logic [15:0]       sd_q;

  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_a, cpu_d,
    output cpu_q, cpu_ack,
    input  fdc_req, fdc_we, fdc_a, fdc_d,
    output fdc_q, fdc_ack,
    output sd_req, sd_a, sd_ds, sd_we, sd_d,
    input  sd_ack, sd_q,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_a, cpu_d,
    input  cpu_q, cpu_ack,
    output fdc_req, fdc_we, fdc_a, fdc_d,
    input  fdc_q, fdc_ack,
    input  sd_req, sd_a, sd_ds, sd_we, sd_d,
    output sd_ack, sd_q,
    input  err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between the Oric CPU bus and the FDC buffer.
// Latency: req to ack is 3 cycles plus sdram turnaround; one access in flight at a time.
// Backpressure: requesters hold req until the 1-cycle ack; a hung sdram aborts after
// TIMEOUT_CYC wait cycles (sticky err, q=FF). Define ARB_RR_EN for round-robin ties.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 clk,
  input logic                 reset_n,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Last timer value that still counts as waiting; the wait cycle holding it aborts.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state;
  logic              sel_fdc;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_a;
  logic [7:0]        lat_d;
  logic [7:0]        timer;

  logic              sd_req_r;
  logic [ADDR_W-2:0] sd_a_r;
  logic [1:0]        sd_ds_r;
  logic              sd_we_r;
  logic [15:0]       sd_d_r;

  logic [7:0]        cpu_q_r;
  logic [7:0]        fdc_q_r;
  logic              cpu_ack_r;
  logic              fdc_ack_r;
  logic              err_r;

  logic              grant_fdc;
  logic [7:0]        rd_byte;

`ifdef ARB_RR_EN
  logic              last_grant_fdc;

  // Round-robin: on a tie the requester that lost last time wins.
  always_comb begin
    grant_fdc = bus.fdc_req && (!bus.cpu_req || !last_grant_fdc);
  end
`else
  // Fixed priority: the FDC only wins when the CPU is not asking.
  always_comb begin
    grant_fdc = bus.fdc_req && !bus.cpu_req;
  end
`endif

  // Odd byte addresses live in the upper lane of the sdram word.
  assign rd_byte = lat_a[0] ? bus.sd_q[15:8] : bus.sd_q[7:0];

  // Access sequencer: grant, issue toggle, wait for ack or timeout, pulse ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel_fdc   <= 1'b0;
      lat_we    <= 1'b0;
      lat_a     <= '0;
      lat_d     <= 8'h00;
      timer     <= 8'h00;
      sd_req_r  <= 1'b0;
      sd_a_r    <= '0;
      sd_ds_r   <= 2'b00;
      sd_we_r   <= 1'b0;
      sd_d_r    <= 16'h0000;
      cpu_q_r   <= 8'h00;
      fdc_q_r   <= 8'h00;
      cpu_ack_r <= 1'b0;
      fdc_ack_r <= 1'b0;
      err_r     <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_fdc <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.fdc_req) begin
            sel_fdc <= grant_fdc;
            lat_we  <= grant_fdc ? bus.fdc_we : bus.cpu_we;
            lat_a   <= grant_fdc ? bus.fdc_a  : bus.cpu_a;
            lat_d   <= grant_fdc ? bus.fdc_d  : bus.cpu_d;
`ifdef ARB_RR_EN
            last_grant_fdc <= grant_fdc;
`endif
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          sd_a_r   <= lat_a[ADDR_W-1:1];
          sd_ds_r  <= lat_a[0] ? 2'b10 : 2'b01;
          sd_we_r  <= lat_we;
          sd_d_r   <= {lat_d, lat_d};
          sd_req_r <= ~sd_req_r;
          timer    <= 8'h00;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.sd_ack == sd_req_r) begin
            if (!lat_we) begin
              if (sel_fdc) fdc_q_r <= rd_byte;
              else         cpu_q_r <= rd_byte;
            end
            if (sel_fdc) fdc_ack_r <= 1'b1;
            else         cpu_ack_r <= 1'b1;
            state <= DONE;
          end else if (timer == TMO_LAST) begin
            err_r <= 1'b1;
            if (sel_fdc) begin
              fdc_q_r   <= 8'hFF;
              fdc_ack_r <= 1'b1;
            end else begin
              cpu_q_r   <= 8'hFF;
              cpu_ack_r <= 1'b1;
            end
            state <= DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          cpu_ack_r <= 1'b0;
          fdc_ack_r <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sd_req  = sd_req_r;
  assign bus.sd_a    = sd_a_r;
  assign bus.sd_ds   = sd_ds_r;
  assign bus.sd_we   = sd_we_r;
  assign bus.sd_d    = sd_d_r;
  assign bus.cpu_q   = cpu_q_r;
  assign bus.fdc_q   = fdc_q_r;
  assign bus.cpu_ack = cpu_ack_r;
  assign bus.fdc_ack = fdc_ack_r;
  assign bus.err     = err_r;

endmodule
